// File: rtl/pad_serial_ctrl.sv
// pad_serial_ctrl: half-duplex single-wire serial controller driving the
// DIN/OEN/PULL inputs of a bidirectional pad and reading its DOUT.
// Frame: start 0, 8 data bits LSB first, optional even parity, stop 1.
// Optional feature macro: PAD_SERIAL_PARITY_EN (adds parity bit on TX/RX).
module pad_serial_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  output logic       PAD_DIN,
  output logic       PAD_OEN,
  output logic [1:0] PAD_PULL,
  input  logic       PAD_DOUT
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_START, S_TX_DATA, S_TX_PAR, S_TX_STOP, S_TX_GUARD,
    S_RX_START, S_RX_DATA, S_RX_PAR, S_RX_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic          sync1;
  logic          sync2;
  logic          line;
  logic          rx_par_err;

`ifdef PAD_SERIAL_PARITY_EN
  logic tx_par;
  logic rx_par_bit;
  assign rx_par_err = rx_par_bit ^ (^rx_shift);
`else
  assign rx_par_err = 1'b0;
`endif

  // Pull-up is always on so a released, undriven line idles high.
  assign PAD_PULL = 2'b11;
  assign line     = sync2;

  // Two-flop synchronizer for the asynchronous pad level.
  // NOTE: both flops reset to 1 (idle line level) so leaving reset never
  // looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= PAD_DOUT;
      sync2 <= sync1;
    end
  end

  // Controller FSM with registered pad and handshake outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      TX_READY <= 1'b0;
      RX_DATA  <= 8'h00;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      PAD_DIN  <= 1'b1;
      PAD_OEN  <= 1'b1;
`ifdef PAD_SERIAL_PARITY_EN
      tx_par     <= 1'b0;
      rx_par_bit <= 1'b0;
`endif
    end else begin
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          PAD_OEN <= 1'b1;
          PAD_DIN <= 1'b1;
          if (!line) begin
            // An incoming start bit wins over a pending send request.
            state    <= S_RX_START;
            TX_READY <= 1'b0;
          end else if (TX_VALID && TX_READY) begin
            tx_shift <= TX_DATA;
`ifdef PAD_SERIAL_PARITY_EN
            tx_par   <= ^TX_DATA;
`endif
            state    <= S_TX_START;
            TX_READY <= 1'b0;
            PAD_OEN  <= 1'b0;
            PAD_DIN  <= 1'b0;
          end else begin
            TX_READY <= 1'b1;
          end
        end
        S_TX_START: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            state    <= S_TX_DATA;
            PAD_DIN  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_TX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_cnt == 4'd7) begin
`ifdef PAD_SERIAL_PARITY_EN
              state   <= S_TX_PAR;
              PAD_DIN <= tx_par;
`else
              state   <= S_TX_STOP;
              PAD_DIN <= 1'b1;
`endif
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              PAD_DIN  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef PAD_SERIAL_PARITY_EN
        S_TX_PAR: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= S_TX_STOP;
            PAD_DIN <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_TX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= S_TX_GUARD;
            PAD_OEN <= 1'b1;
            PAD_DIN <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_TX_GUARD: begin
          // Line released but ignored so our own stop bit is not received.
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            state    <= S_IDLE;
            TX_READY <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (line) begin
              state    <= S_IDLE;
              TX_READY <= 1'b1;
            end else begin
              state   <= S_RX_DATA;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            rx_shift <= {line, rx_shift[7:1]};
            if (bit_cnt == 4'd7) begin
`ifdef PAD_SERIAL_PARITY_EN
              state <= S_RX_PAR;
`else
              state <= S_RX_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef PAD_SERIAL_PARITY_EN
        S_RX_PAR: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            rx_par_bit <= line;
            state      <= S_RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_RX_STOP: begin
          // The byte is delivered even when the frame is flagged as bad.
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            RX_DATA  <= rx_shift;
            RX_VALID <= 1'b1;
            RX_ERR   <= ~line | rx_par_err;
            state    <= S_IDLE;
            TX_READY <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_serial_ctrl.sv
// Self-checking bench for pad_serial_ctrl (CLKS_PER_BIT=4). Expected pad
// and handshake waveforms are scheduled per cycle from the frame rules and
// compared against the DUT on every falling edge.
module tb_pad_serial_ctrl;

  localparam int CPB  = 4;
`ifdef PAD_SERIAL_PARITY_EN
  localparam int NB   = 11;
`else
  localparam int NB   = 10;
`endif
  localparam int MAXC = 8000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ERR;
  logic       PAD_DIN;
  logic       PAD_OEN;
  logic [1:0] PAD_PULL;
  logic       PAD_DOUT;
  logic       ext_line = 1'b1;

  // Pad model: the core drives when OEN=0, otherwise the remote side.
  assign PAD_DOUT = PAD_OEN ? ext_line : PAD_DIN;

  pad_serial_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_ERR(RX_ERR), .PAD_DIN(PAD_DIN), .PAD_OEN(PAD_OEN),
    .PAD_PULL(PAD_PULL), .PAD_DOUT(PAD_DOUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle expectation schedule, indexed by rising-edge count.
  bit         exp_oen  [MAXC];
  bit         exp_din  [MAXC];
  bit         rdy_care [MAXC];
  bit         exp_rdy  [MAXC];
  bit         exp_vld  [MAXC];
  bit         exp_err  [MAXC];
  logic [7:0] exp_dat  [MAXC];
  logic [7:0] model_rx_data = 8'h00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit fbit(input logic [7:0] d, input int j, input bit stop, input bit par_ok);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
`ifdef PAD_SERIAL_PARITY_EN
    if (j == 9) return (^d) ^ !par_ok;
`endif
    return stop;
  endfunction

  task automatic set_rdy(input int n, input bit v);
    if (n >= 0 && n < MAXC) begin
      rdy_care[n] = 1'b1;
      exp_rdy[n]  = v;
    end
  endtask

  task automatic clear_sched(input int from, input int upto);
    for (int n = from; n <= upto && n < MAXC; n++) begin
      exp_oen[n] = 1'b1; exp_din[n] = 1'b1; rdy_care[n] = 1'b0;
      exp_vld[n] = 1'b0; exp_err[n] = 1'b0;
    end
  endtask

  // Compare process: every falling edge, DUT outputs against the schedule.
  always @(negedge CLK) begin
    if (RST) begin
      model_rx_data = 8'h00;
      check("rst_oen",  8'(PAD_OEN),  8'd1);
      check("rst_din",  8'(PAD_DIN),  8'd1);
      check("rst_pull", 8'(PAD_PULL), 8'd3);
      check("rst_rdy",  8'(TX_READY), 8'd0);
      check("rst_vld",  8'(RX_VALID), 8'd0);
      check("rst_err",  8'(RX_ERR),   8'd0);
      check("rst_data", RX_DATA,      8'h00);
    end else if (cyc < MAXC) begin
      if (exp_vld[cyc]) model_rx_data = exp_dat[cyc];
      check("oen",     8'(PAD_OEN),  8'(exp_oen[cyc]));
      if (!exp_oen[cyc]) check("din", 8'(PAD_DIN), 8'(exp_din[cyc]));
      check("pull",    8'(PAD_PULL), 8'd3);
      check("rx_vld",  8'(RX_VALID), 8'(exp_vld[cyc]));
      check("rx_err",  8'(RX_ERR),   8'(exp_err[cyc]));
      check("rx_data", RX_DATA,      model_rx_data);
      if (rdy_care[cyc]) check("tx_rdy", 8'(TX_READY), 8'(exp_rdy[cyc]));
    end
  end

  // Present one byte for one cycle while idle; returns on the falling edge
  // after the accept edge t, from which the start bit must be driven.
  task automatic do_tx_start(input logic [7:0] d, output int t);
    @(negedge CLK);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    t = cyc + 1;
    for (int n = t; n < t + (NB + 1) * CPB && n < MAXC; n++) begin
      if (n < t + NB * CPB) begin
        exp_oen[n] = 1'b0;
        exp_din[n] = fbit(d, (n - t) / CPB, 1'b1, 1'b1);
      end
      set_rdy(n, 1'b0);
    end
    for (int k = 0; k < 3; k++) set_rdy(t + (NB + 1) * CPB + k, 1'b1);
    @(negedge CLK);
    TX_VALID = 1'b0;
    TX_DATA  = 8'($urandom);
  endtask

  // Drive one frame on the remote side; s is the cycle RX_VALID must show.
  task automatic do_rx(input logic [7:0] d, input bit stop, input bit par_ok,
                       input bit collide, output int s);
    int f;
    @(negedge CLK);
    f = cyc;
    s = f + 3 + CPB / 2 + (NB - 1) * CPB;
    for (int n = f + 3; n < s; n++) set_rdy(n, 1'b0);
    if (collide) set_rdy(f + 2, 1'b1);
    if (s < MAXC) begin
      exp_vld[s] = 1'b1;
      exp_dat[s] = d;
      exp_err[s] = !stop || !par_ok;
    end
    for (int j = 0; j < NB; j++) begin
      ext_line = fbit(d, j, stop, par_ok);
      if (collide && j == 0) begin
        repeat (2) @(negedge CLK);
        TX_DATA  = 8'($urandom);
        TX_VALID = 1'b1;
        @(negedge CLK);
        TX_VALID = 1'b0;
        repeat (CPB - 3) @(negedge CLK);
      end else begin
        repeat (CPB) @(negedge CLK);
      end
    end
    ext_line = 1'b1;
  endtask

  task automatic do_glitch();
    int f;
    @(negedge CLK);
    f = cyc;
    ext_line = 1'b0;
    set_rdy(f + 3, 1'b0);
    for (int k = 0; k < 3; k++) set_rdy(f + 3 + CPB / 2 + k, 1'b1);
    @(negedge CLK);
    ext_line = 1'b1;
  endtask

  task automatic gap(input int n);
    for (int i = cyc + 2 * CPB; i <= cyc + n; i++) set_rdy(i, 1'b1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  logic rec_oen [64];
  logic rec_din [64];
  logic rec_rdy [64];
`ifdef PAD_SERIAL_PARITY_EN
  bit a5_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  bit coll_err = 1'b1;
`else
  bit a5_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
  bit coll_err = 1'b0;
`endif

  initial begin
    int t, s, r, n_low;
    logic [7:0] d;
    for (int n = 0; n < MAXC; n++) begin
      exp_oen[n] = 1'b1; exp_din[n] = 1'b1; rdy_care[n] = 1'b0;
      exp_rdy[n] = 1'b0; exp_vld[n] = 1'b0; exp_err[n] = 1'b0;
      exp_dat[n] = 8'h00;
    end

    // Power-on reset.
    #1 RST = 1'b1;
    @(negedge CLK);
    check("por_rx_data", RX_DATA, 8'h00);
    check("por_tx_rdy", 8'(TX_READY), 8'd0);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    r = cyc;
    set_rdy(r, 1'b0);
    set_rdy(r + 1, 1'b1);
    @(negedge CLK);
    gap(3 * CPB);

    // Directed TX of 8'hA5 with recorded waveform.
    do_tx_start(8'hA5, t);
    for (int i = 0; i < (NB + 2) * CPB; i++) begin
      rec_oen[i] = PAD_OEN;
      rec_din[i] = PAD_DIN;
      rec_rdy[i] = TX_READY;
      @(negedge CLK);
    end
    n_low = 0;
    for (int i = 0; i < (NB + 2) * CPB; i++) if (rec_oen[i] === 1'b0) n_low++;
    check("a5_oen_low_cycles", 8'(n_low), 8'(NB * CPB));
    for (int j = 0; j < NB; j++)
      check("a5_din_bit", 8'(rec_din[j * CPB + CPB / 2]), 8'(a5_seq[j]));
    check("a5_rdy_before", 8'(rec_rdy[(NB + 1) * CPB - 1]), 8'd0);
    check("a5_rdy_after",  8'(rec_rdy[(NB + 1) * CPB]),     8'd1);
    gap(3 * CPB);

    // Directed RX of 8'h3C, clean frame.
    do_rx(8'h3C, 1'b1, 1'b1, 1'b0, s);
    wait_cyc(s);
    check("rx3c_valid", 8'(RX_VALID), 8'd1);
    check("rx3c_data",  RX_DATA,      8'h3C);
    check("rx3c_err",   8'(RX_ERR),   8'd0);
    gap(3 * CPB);

    // Framing error: stop bit 0.
    do_rx(8'h55, 1'b0, 1'b1, 1'b0, s);
    wait_cyc(s);
    check("rx55_valid", 8'(RX_VALID), 8'd1);
    check("rx55_data",  RX_DATA,      8'h55);
    check("rx55_err",   8'(RX_ERR),   8'd1);
    gap(3 * CPB);

    // One-cycle glitch while idle.
    do_glitch();
    gap(3 * CPB);

    // Collision: send request in the cycle the line first reads low.
    do_rx(8'h01, 1'b1, !coll_err, 1'b1, s);
    wait_cyc(s);
    check("coll_valid", 8'(RX_VALID), 8'd1);
    check("coll_data",  RX_DATA,      8'h01);
    check("coll_err",   8'(RX_ERR),   8'(coll_err));
    gap(3 * CPB);

    // Reset asserted 10 cycles into a transmit frame.
    do_tx_start(8'($urandom), t);
    wait_cyc(t + 9);
    @(posedge CLK);
    #2 RST = 1'b1;
    clear_sched(cyc, cyc + 200);
    #1;
    check("midrst_oen",  8'(PAD_OEN),  8'd1);
    check("midrst_din",  8'(PAD_DIN),  8'd1);
    check("midrst_pull", 8'(PAD_PULL), 8'd3);
    check("midrst_rdy",  8'(TX_READY), 8'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    r = cyc;
    set_rdy(r, 1'b0);
    set_rdy(r + 1, 1'b1);
    @(negedge CLK);
    gap(3 * CPB);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          do_tx_start(d, t);
          wait_cyc(t + (NB + 1) * CPB);
        end
        1: do_rx(d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0 || NB == 10, 1'b0, s);
        2: do_glitch();
        default: do_rx(d, 1'b1, $urandom_range(0, 1) != 0 || NB == 10, 1'b1, s);
      endcase
      gap(3 * CPB + int'($urandom_range(0, 7)));
    end

    gap(2 * CPB);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
